// File: rtl/source_ser_1bit.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on valid/ready and shifts them out
// MSB-first, one bit per enabled clk, with an optional idle gap after each word.
module source_ser_1bit #(
    parameter int WIDTH = 16,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    input  logic             out_en,
    output logic             data_out,
    output logic             data_en_out,
    output logic             frame_end,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_last;
    logic [GW-1:0]    r_gcnt;
    logic             r_data_out;
    logic             r_data_en;
    logic             r_frame_end;

    logic w_last_bit;
    logic w_ready;
    logic w_xfer;

    // Handshake: a word transfers on a rising edge where din_valid and din_ready are both high.
    // din_ready depends only on registered state and out_en, never on din_valid.
    assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == CNT_LAST) && out_en;
    assign w_ready    = rst_n && ((r_state == S_IDLE) || (w_last_bit && (GAP == 0)));
    assign w_xfer     = din_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_gcnt      <= '0;
            r_data_out  <= 1'b0;
            r_data_en   <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_data_en   <= 1'b0;
                    r_frame_end <= 1'b0;
                    if (w_xfer) begin
                        r_shreg <= din;
                        r_last  <= din_last;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (out_en) begin
                        r_data_out  <= r_shreg[WIDTH-1];
                        r_data_en   <= 1'b1;
                        r_frame_end <= (r_cnt == CNT_LAST) && r_last;
                        if (r_cnt != CNT_LAST) begin
                            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                            r_cnt   <= r_cnt + 1'b1;
                        end else if (w_xfer) begin
                            // Back-to-back reload keeps the stream continuous.
                            r_shreg <= din;
                            r_last  <= din_last;
                            r_cnt   <= '0;
                        end else begin
                            r_shreg <= '0;
                            r_cnt   <= '0;
                            r_gcnt  <= '0;
                            r_state <= (GAP > 0) ? S_GAP : S_IDLE;
                        end
                    end else begin
                        r_data_en   <= 1'b0;
                        r_frame_end <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_data_en   <= 1'b0;
                    r_frame_end <= 1'b0;
                    if (r_gcnt == GCNT_LAST) begin
                        r_gcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign din_ready   = w_ready;
    assign data_out    = r_data_out;
    assign data_en_out = r_data_en;
    assign frame_end   = r_frame_end;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule
